// File: rtl/pulse_gen_monitor.sv
// Receiver/checker for a pulse_gen output stream: measures high/low widths in clk
// cycles, checks them against nominal +/- tolerance, counts pulses, reports errors and lock.
module pulse_gen_monitor #(
    parameter int ACTIVE_CYCLES_P     = 10,
    parameter int NON_ACTIVE_CYCLES_P = 10,
    parameter int TOL_P               = 1,
    parameter int LOCK_P              = 4,
    parameter int TIMEOUT_P           = 64,
    parameter int CNT_W               = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pulse_in,
    input  logic             clear_errors,
    output logic [CNT_W-1:0] active_width,
    output logic [CNT_W-1:0] non_active_width,
    output logic             width_valid,
    output logic [CNT_W-1:0] pulse_count,
    output logic             active_err,
    output logic             non_active_err,
    output logic             stuck_err,
    output logic [CNT_W-1:0] err_count,
    output logic             locked
);

    typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] ACT_C  = CNT_W'(ACTIVE_CYCLES_P);
    localparam logic [CNT_W-1:0] NACT_C = CNT_W'(NON_ACTIVE_CYCLES_P);
    localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL_P);
    localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_P);
    localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT_P);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MAX_C  = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX_C) ? v : v + ONE_C;
    endfunction

    function automatic logic in_tol(input logic [CNT_W-1:0] w, input logic [CNT_W-1:0] e);
        logic [CNT_W-1:0] diff;
        diff = (w >= e) ? (w - e) : (e - w);
        return diff <= TOL_C;
    endfunction

    // Reset asserts asynchronously, releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    // prime_q marks when every sync stage holds a real sample, so the chain filling
    // after reset with pulse_in already high is not mistaken for a rising edge.
    logic [2:0] sync_q;
    logic [2:0] prime_q;
    logic       s2;
    logic       rise;
    logic       fall;

    assign s2   = sync_q[1];
    assign rise = prime_q[2] &  sync_q[1] & ~sync_q[2];
    assign fall = prime_q[2] & ~sync_q[1] &  sync_q[2];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_w_q, act_w_d;
    logic [CNT_W-1:0] nact_w_q, nact_w_d;
    logic             wv_q, wv_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic             ae_q, ae_d;
    logic             ne_q, ne_d;
    logic             se_q, se_d;
    logic [CNT_W-1:0] ec_q, ec_d;
    logic [CNT_W-1:0] gr_q, gr_d;
    logic             hok_q, hok_d;
    logic             locked_q, locked_d;
    logic             err_event;
    logic             low_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            prime_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            act_w_q  <= '0;
            nact_w_q <= '0;
            wv_q     <= 1'b0;
            pc_q     <= '0;
            ae_q     <= 1'b0;
            ne_q     <= 1'b0;
            se_q     <= 1'b0;
            ec_q     <= '0;
            gr_q     <= '0;
            hok_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], pulse_in};
            prime_q  <= {prime_q[1:0], 1'b1};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            act_w_q  <= act_w_d;
            nact_w_q <= nact_w_d;
            wv_q     <= wv_d;
            pc_q     <= pc_d;
            ae_q     <= ae_d;
            ne_q     <= ne_d;
            se_q     <= se_d;
            ec_q     <= ec_d;
            gr_q     <= gr_d;
            hok_q    <= hok_d;
            locked_q <= locked_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_w_d   = act_w_q;
        nact_w_d  = nact_w_q;
        wv_d      = 1'b0;
        pc_d      = pc_q;
        gr_d      = gr_q;
        hok_d     = hok_q;
        err_event = 1'b0;
        low_ok    = 1'b0;
        // Clearing first lets an error detected in the same cycle win.
        ae_d      = clear_errors ? 1'b0 : ae_q;
        ne_d      = clear_errors ? 1'b0 : ne_q;
        se_d      = clear_errors ? 1'b0 : se_q;
        ec_d      = clear_errors ? '0   : ec_q;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            gr_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    gr_d = '0;
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        cnt_d   = ONE_C;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        act_w_d = cnt_q;
                        wv_d    = 1'b1;
                        pc_d    = pc_q + ONE_C;
                        hok_d   = in_tol(cnt_q, ACT_C);
                        if (!hok_d) begin
                            ae_d      = 1'b1;
                            err_event = 1'b1;
                            gr_d      = '0;
                        end
                        state_d = MEAS_LOW;
                        cnt_d   = ONE_C;
                    end else if (cnt_q >= TO_C) begin
                        se_d      = 1'b1;
                        err_event = 1'b1;
                        gr_d      = '0;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else if (s2) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        nact_w_d = cnt_q;
                        wv_d     = 1'b1;
                        low_ok   = in_tol(cnt_q, NACT_C);
                        if (!low_ok) begin
                            ne_d      = 1'b1;
                            err_event = 1'b1;
                            gr_d      = '0;
                        end else if (hok_q) begin
                            gr_d = sat_inc(gr_q);
                        end else begin
                            gr_d = '0;
                        end
                        state_d = MEAS_HIGH;
                        cnt_d   = ONE_C;
                    end else if (cnt_q >= TO_C) begin
                        se_d      = 1'b1;
                        err_event = 1'b1;
                        gr_d      = '0;
                        state_d   = IDLE;
                        cnt_d     = '0;
                    end else if (!s2) begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    gr_d    = '0;
                end
            endcase
        end

        if (err_event) ec_d = sat_inc(ec_d);
        locked_d = (gr_d >= LOCK_C);
    end

    assign active_width     = act_w_q;
    assign non_active_width = nact_w_q;
    assign width_valid      = wv_q;
    assign pulse_count      = pc_q;
    assign active_err       = ae_q;
    assign non_active_err   = ne_q;
    assign stuck_err        = se_q;
    assign err_count        = ec_q;
    assign locked           = locked_q;

endmodule

// File: tb/tb_pulse_gen_monitor.sv
// Bench for pulse_gen_monitor: drives pulse_in as a sequence of levels and predicts
// the outputs from the level lengths alone.
module tb_pulse_gen_monitor;
    localparam int A = 10, NA = 10, TOL = 1, LOCK = 4, TO = 64, W = 16;

    logic clk = 0, reset_n = 0, enable = 0, pulse_in = 0, clear_errors = 0;
    logic [W-1:0] active_width, non_active_width, pulse_count, err_count;
    logic width_valid, active_err, non_active_err, stuck_err, locked;

    int checks = 0, errors = 0, wv_seen = 0;
    // Level-based model: m_state 0 = waiting for a rise, 1 = current level is a measured
    // high, 2 = current level is a measured low; pend_n = length of current level so far.
    int m_state = 0, pend_n = 0, m_on = 1;
    int m_aw = 0, m_nw = 0, m_pc = 0, m_ec = 0, m_gr = 0, m_wv = 0;
    bit m_ae = 0, m_ne = 0, m_se = 0, m_hok = 0;

    pulse_gen_monitor #(.ACTIVE_CYCLES_P(A), .NON_ACTIVE_CYCLES_P(NA), .TOL_P(TOL),
                        .LOCK_P(LOCK), .TIMEOUT_P(TO), .CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pulse_in(pulse_in),
        .clear_errors(clear_errors), .active_width(active_width),
        .non_active_width(non_active_width), .width_valid(width_valid),
        .pulse_count(pulse_count), .active_err(active_err), .non_active_err(non_active_err),
        .stuck_err(stuck_err), .err_count(err_count), .locked(locked));

    always #5 clk = ~clk;
    always @(negedge clk) if (width_valid === 1'b1) wv_seen++;

    function automatic bit in_tol(int w, int e);
        int d;
        d = w - e;
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    task automatic model_err();
        if (m_ec < 65535) m_ec++;
        m_gr = 0;
    endtask

    task automatic model_close();
        bit ok;
        if (m_state == 1) begin
            m_aw = pend_n; m_wv++; m_pc = (m_pc + 1) % 65536;
            m_hok = in_tol(pend_n, A);
            if (!m_hok) begin m_ae = 1; model_err(); end
            m_state = 2;
        end else if (m_state == 2) begin
            ok = in_tol(pend_n, NA);
            m_nw = pend_n; m_wv++;
            if (!ok) begin m_ne = 1; model_err(); end
            else if (m_hok) m_gr++;
            else m_gr = 0;
            m_state = 1;
        end
    endtask

    // Hold pulse_in at v for n clocks; same level as now just lengthens it.
    task automatic seg(input logic v, input int n);
        if (v !== pulse_in) begin
            model_close();
            pulse_in = v;
            pend_n = 0;
            if (m_on != 0 && m_state == 0 && v) m_state = 1;
        end
        repeat (n) begin
            @(posedge clk); #1;
            pend_n++;
            if (m_state != 0 && pend_n > TO) begin m_state = 0; m_se = 1; model_err(); end
        end
    endtask

    task automatic test_reset();
        reset_n = 0; enable = 0;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({active_width, non_active_width, pulse_count, err_count, width_valid,
             active_err, non_active_err, stuck_err, locked} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", {active_width,
                non_active_width, pulse_count, err_count, width_valid, active_err,
                non_active_err, stuck_err, locked});
        end
        reset_n = 1;
        seg(0, 6);
        enable = 1;
        seg(0, 4);
    endtask

    task automatic test_nominal();
        for (int i = 0; i < 8; i++) begin
            seg(1, 10);
            checks++;
            if (locked !== (m_gr >= LOCK)) begin
                errors++; $display("FAIL nominal_locked[%0d]: got %0d expected %0d", i, locked, m_gr >= LOCK);
            end
            seg(0, 10);
        end
        seg(1, 10);
        checks++;
        if (active_width !== 16'(m_aw)) begin errors++; $display("FAIL nominal_aw: got %0d expected %0d", active_width, m_aw); end
        checks++;
        if (non_active_width !== 16'(m_nw)) begin errors++; $display("FAIL nominal_nw: got %0d expected %0d", non_active_width, m_nw); end
        checks++;
        if (pulse_count !== 16'(m_pc)) begin errors++; $display("FAIL nominal_pc: got %0d expected %0d", pulse_count, m_pc); end
        checks++;
        if (err_count !== 16'(m_ec)) begin errors++; $display("FAIL nominal_ec: got %0d expected %0d", err_count, m_ec); end
        checks++;
        if (wv_seen !== m_wv) begin errors++; $display("FAIL nominal_wv: got %0d expected %0d", wv_seen, m_wv); end
    endtask

    task automatic test_width_error();
        seg(0, 10); seg(1, 13); seg(0, 10);
        checks++;
        if (active_width !== 16'(m_aw)) begin errors++; $display("FAIL werr_aw: got %0d expected %0d", active_width, m_aw); end
        checks++;
        if (active_err !== m_ae) begin errors++; $display("FAIL werr_flag: got %0d expected %0d", active_err, m_ae); end
        checks++;
        if (err_count !== 16'(m_ec)) begin errors++; $display("FAIL werr_ec: got %0d expected %0d", err_count, m_ec); end
        for (int i = 0; i < 5; i++) begin
            seg(1, 10);
            checks++;
            if (locked !== (m_gr >= LOCK)) begin
                errors++; $display("FAIL werr_relock[%0d]: got %0d expected %0d", i, locked, m_gr >= LOCK);
            end
            seg(0, 10);
        end
        seg(1, 10);
    endtask

    task automatic test_boundary();
        seg(0, 10); seg(1, 64); seg(0, 11);
        checks++;
        if (active_width !== 16'(m_aw)) begin errors++; $display("FAIL bnd_aw64: got %0d expected %0d", active_width, m_aw); end
        checks++;
        if ({active_err, stuck_err} !== {m_ae, m_se}) begin
            errors++; $display("FAIL bnd_flags: got %b%b expected %b%b", active_err, stuck_err, m_ae, m_se);
        end
        seg(1, 9); seg(0, 8); seg(1, 10);
        checks++;
        if (non_active_err !== m_ne) begin errors++; $display("FAIL bnd_ne: got %0d expected %0d", non_active_err, m_ne); end
        checks++;
        if (err_count !== 16'(m_ec)) begin errors++; $display("FAIL bnd_ec: got %0d expected %0d", err_count, m_ec); end
    endtask

    task automatic test_stuck();
        int wv0;
        seg(0, 10);
        wv0 = wv_seen;
        seg(1, 100);
        checks++;
        if (stuck_err !== m_se) begin errors++; $display("FAIL stuck_flag: got %0d expected %0d", stuck_err, m_se); end
        checks++;
        if (wv_seen !== m_wv) begin errors++; $display("FAIL stuck_wv: got %0d expected %0d (before %0d)", wv_seen, m_wv, wv0); end
        checks++;
        if (locked !== (m_gr >= LOCK)) begin errors++; $display("FAIL stuck_locked: got %0d expected %0d", locked, m_gr >= LOCK); end
        seg(0, 10); seg(1, 10); seg(0, 10); seg(1, 10);
        checks++;
        if ({active_width, non_active_width, pulse_count} !== {16'(m_aw), 16'(m_nw), 16'(m_pc)}) begin
            errors++; $display("FAIL stuck_recover: got aw=%0d nw=%0d pc=%0d expected aw=%0d nw=%0d pc=%0d",
                active_width, non_active_width, pulse_count, m_aw, m_nw, m_pc);
        end
    endtask

    task automatic test_back_to_back();
        seg(0, 10); seg(1, 1); seg(0, 1); seg(1, 2); seg(0, 1); seg(1, 1); seg(0, 8);
        checks++;
        if ({active_width, non_active_width} !== {16'(m_aw), 16'(m_nw)}) begin
            errors++; $display("FAIL b2b_widths: got %0d/%0d expected %0d/%0d", active_width, non_active_width, m_aw, m_nw);
        end
        checks++;
        if (wv_seen !== m_wv) begin errors++; $display("FAIL b2b_wv: got %0d expected %0d", wv_seen, m_wv); end
        checks++;
        if (err_count !== 16'(m_ec)) begin errors++; $display("FAIL b2b_ec: got %0d expected %0d", err_count, m_ec); end
        seg(1, 10);
    endtask

    task automatic test_clear_errors();
        seg(0, 10); seg(1, 13); seg(0, 2);
        clear_errors = 1;
        seg(0, 1);
        clear_errors = 0;
        m_ne = 0; m_se = 0; m_ec = 1;
        seg(0, 3);
        checks++;
        if ({active_err, non_active_err, stuck_err} !== {m_ae, m_ne, m_se}) begin
            errors++; $display("FAIL clr_same_flags: got %b%b%b expected %b%b%b", active_err, non_active_err, stuck_err, m_ae, m_ne, m_se);
        end
        checks++;
        if (err_count !== 16'(m_ec)) begin errors++; $display("FAIL clr_same_ec: got %0d expected %0d", err_count, m_ec); end
        clear_errors = 1;
        seg(0, 1);
        clear_errors = 0;
        m_ae = 0; m_ne = 0; m_se = 0; m_ec = 0;
        seg(0, 2);
        checks++;
        if ({active_err, non_active_err, stuck_err, err_count} !== {m_ae, m_ne, m_se, 16'(m_ec)}) begin
            errors++; $display("FAIL clr_alone: got %b%b%b ec=%0d expected %b%b%b ec=%0d", active_err, non_active_err,
                stuck_err, err_count, m_ae, m_ne, m_se, m_ec);
        end
        seg(1, 10);
    endtask

    task automatic test_enable();
        seg(0, 10); seg(1, 5);
        enable = 0; m_on = 0; m_state = 0; m_gr = 0;
        seg(1, 5); seg(0, 10); seg(1, 10); seg(0, 5);
        enable = 1; m_on = 1;
        checks++;
        if (wv_seen !== m_wv) begin errors++; $display("FAIL en_wv: got %0d expected %0d", wv_seen, m_wv); end
        checks++;
        if ({active_width, non_active_width, pulse_count, err_count} !==
            {16'(m_aw), 16'(m_nw), 16'(m_pc), 16'(m_ec)}) begin
            errors++; $display("FAIL en_hold: got aw=%0d nw=%0d pc=%0d ec=%0d expected %0d %0d %0d %0d", active_width,
                non_active_width, pulse_count, err_count, m_aw, m_nw, m_pc, m_ec);
        end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL en_locked: got %0d expected 0", locked); end
        seg(0, 15); seg(1, 10); seg(0, 10); seg(1, 10);
        checks++;
        if ({active_width, non_active_width, pulse_count} !== {16'(m_aw), 16'(m_nw), 16'(m_pc)}) begin
            errors++; $display("FAIL en_resume: got aw=%0d nw=%0d pc=%0d expected %0d %0d %0d",
                active_width, non_active_width, pulse_count, m_aw, m_nw, m_pc);
        end
    endtask

    task automatic test_async_reset();
        seg(0, 10); seg(1, 5);
        #2 reset_n = 0;
        #1;
        checks++;
        if ({active_width, non_active_width, pulse_count, err_count, width_valid,
             active_err, non_active_err, stuck_err, locked} !== '0) begin
            errors++; $display("FAIL areset_outputs: got %h expected 0", {active_width, non_active_width,
                pulse_count, err_count, width_valid, active_err, non_active_err, stuck_err, locked});
        end
        m_state = 0; m_aw = 0; m_nw = 0; m_pc = 0; m_ec = 0; m_gr = 0;
        m_ae = 0; m_ne = 0; m_se = 0; m_hok = 0;
        @(posedge clk); #1;
        reset_n = 1;
        seg(1, 12); seg(0, 10);
        checks++;
        if ({pulse_count, 16'(wv_seen)} !== {16'(m_pc), 16'(m_wv)}) begin
            errors++; $display("FAIL areset_partial: got pc=%0d wv=%0d expected %0d %0d", pulse_count, wv_seen, m_pc, m_wv);
        end
        seg(1, 10); seg(0, 10); seg(1, 10);
        checks++;
        if ({active_width, non_active_width, pulse_count} !== {16'(m_aw), 16'(m_nw), 16'(m_pc)}) begin
            errors++; $display("FAIL areset_resume: got aw=%0d nw=%0d pc=%0d expected %0d %0d %0d",
                active_width, non_active_width, pulse_count, m_aw, m_nw, m_pc);
        end
    endtask

    task automatic test_random();
        int len;
        for (int i = 0; i < 40; i++) begin
            len = ($urandom_range(0, 9) < 6) ? int'($urandom_range(8, 12)) : int'($urandom_range(1, 30));
            seg(~pulse_in, len);
        end
        seg(pulse_in, 6);
        checks++;
        if ({active_width, non_active_width, pulse_count, err_count} !==
            {16'(m_aw), 16'(m_nw), 16'(m_pc), 16'(m_ec)}) begin
            errors++; $display("FAIL rand_values: got aw=%0d nw=%0d pc=%0d ec=%0d expected %0d %0d %0d %0d", active_width,
                non_active_width, pulse_count, err_count, m_aw, m_nw, m_pc, m_ec);
        end
        checks++;
        if ({active_err, non_active_err, stuck_err, locked} !== {m_ae, m_ne, m_se, m_gr >= LOCK}) begin
            errors++; $display("FAIL rand_flags: got %b%b%b%b expected %b%b%b%b", active_err, non_active_err, stuck_err,
                locked, m_ae, m_ne, m_se, m_gr >= LOCK);
        end
        checks++;
        if (wv_seen !== m_wv) begin errors++; $display("FAIL rand_wv: got %0d expected %0d", wv_seen, m_wv); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_width_error();
        test_boundary();
        test_stuck();
        test_back_to_back();
        test_clear_errors();
        test_enable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
